i2c_reg_script_seq: RTL and testbench
=====================================

// Module: i2c_reg_script_seq
// PURPOSE
//  Generic I2C register-script sequencer; successor to the fixed single-sensor write-only config FSM.
//  Walks a script held in an external sync ROM: register writes, timed delays, read-and-verify (e.g. chip ID).
//  Drives one I2C byte-master through a req/done handshake; NACKs are retried, all faults reported.
//  Sits between camera/sensor top-level bring-up logic and the I2C master core.
// PARAMETERS
//  SLAVE_ADDR     7'h60     7-bit device address; R/W bit appended by master
//  REG_ADDR_BYTES 2         register address bytes (1..2), sent MSB first
//  SCRIPT_DEPTH   128       max ROM entries; IDX_W = $clog2(SCRIPT_DEPTH)
//  DELAY_UNIT_CYC 50000     clk cycles per DELAY tick (1 ms @ 50 MHz)
//  MAX_RETRY      3         reissues of one entry after NACK before error
//  RETRY_GAP_CYC  1000      idle cycles between a NACK and the reissue
//  TIMEOUT_CYC    1000000   max cycles from o_mst_req to i_mst_done
//  ENTRY_W = 2 + 8*REG_ADDR_BYTES + 8: entry = {op[1:0], reg_addr, val[7:0]}
// PORTS
//  i_clk          in   1        clock
//  i_rst          in   1        reset, synchronous, active-high
//  i_start        in   1        pulse: run script from index 0 (ignored while o_busy)
//  o_rom_addr     out  IDX_W    script ROM address
//  i_rom_data     in   ENTRY_W  ROM data, valid 1 cycle after o_rom_addr
//  o_mst_req      out  1        1-cycle transaction request
//  o_mst_rw       out  1        0 = write reg_addr+val; 1 = write reg_addr, rep. start, read 1 byte
//  o_mst_slave    out  7        SLAVE_ADDR
//  o_mst_reg      out  8*RAB    register address, held stable req..done
//  o_mst_wdata    out  8        write data, held stable req..done
//  i_mst_done     in   1        1-cycle transaction-complete pulse
//  i_mst_nack     in   1        NACK seen; valid with i_mst_done
//  i_mst_arb_lost in   1        arbitration lost; valid with i_mst_done
//  i_mst_rdata    in   8        read byte; valid with i_mst_done when o_mst_rw=1
//  o_busy         out  1        high in every state except IDLE/DONE/ERROR
//  o_done         out  1        level: script reached END cleanly
//  o_error        out  1        level: script aborted
//  o_err_code     out  3        1 NACK, 2 ARB, 3 MISMATCH, 4 TIMEOUT, 5 OVERRUN; 0 otherwise
//  o_err_index    out  IDX_W    entry index at fault
//  o_rd_val       out  8        last byte read by a VERIFY
// BEHAVIOUR
//  Reset: state IDLE, index 0, all outputs 0 (o_mst_slave constant SLAVE_ADDR).
//  Ops: 0 WRITE, 1 DELAY (val*DELAY_UNIT_CYC cycles; val=0 -> 0 wait), 2 VERIFY (read, compare to val), 3 END.
//  States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, GAP, DONE, ERROR.
//  IDLE/DONE/ERROR + i_start -> FETCH; clears index, retry count, o_done, o_error, o_err_code.
//  FETCH: drive o_rom_addr=index -> DECODE next cycle registers i_rom_data.
//  DECODE: WRITE/VERIFY -> ISSUE; DELAY -> DELAY; END -> DONE.
//  ISSUE: o_mst_req=1 for exactly 1 cycle, timeout counter cleared -> WAIT.
//  WAIT on i_mst_done: arb_lost -> ERROR(2) (priority over nack); nack -> retry path;
//   VERIFY and rdata!=val -> ERROR(3), o_rd_val updated; else success (o_rd_val updated on VERIFY).
//  WAIT exceeding TIMEOUT_CYC without done -> ERROR(4).
//  Retry path: retry_cnt < MAX_RETRY -> retry_cnt++, GAP for RETRY_GAP_CYC, then ISSUE same entry;
//   retry_cnt == MAX_RETRY -> ERROR(1). Total attempts per entry = MAX_RETRY+1.
//  Success / DELAY expiry: retry_cnt=0, index++ -> FETCH; index==SCRIPT_DEPTH-1 (no END) -> ERROR(5).
//  DONE: o_done=1 held. ERROR: o_error=1, o_err_code/o_err_index held; no master requests issued.
//  i_start while o_busy ignored; i_rst mid-transaction returns IDLE at once (master reset separately).
//  Delay/gap/timeout counters sized by $clog2 of max product; no wrap within legal range.
// TESTING
//  Script {W 0103=01, D 5, V 300A=92, END}, ACKing model -> 1 write, ~5*DELAY_UNIT gap, 1 read, o_done=1.
//  Model NACKs entry 0 twice, then ACKs, MAX_RETRY=3 -> 3 reqs RETRY_GAP_CYC apart, o_done=1.
//  Model NACKs always -> exactly 4 reqs, o_error=1, o_err_code=1, o_err_index=0.
//  VERIFY 300B expects 81, model returns 80 -> o_err_code=3, o_rd_val=8'h80, no further reqs.
//  Done never returned -> o_err_code=4 after TIMEOUT_CYC; arb_lost+nack together -> code 2.
//  Script without END (depth 4) -> code 5, index 3; i_rst mid-WAIT -> IDLE, outputs 0, restart OK.

Source files
------------

// File: rtl/i2c_reg_script_seq.sv
// Register-script sequencer: walks a sync ROM of WRITE/DELAY/VERIFY/END entries and
// drives a single I2C byte-master through a req/done handshake with NACK retry.
module i2c_reg_script_seq #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h60,
  parameter int unsigned REG_ADDR_BYTES = 2,
  parameter int unsigned SCRIPT_DEPTH   = 128,
  parameter int unsigned DELAY_UNIT_CYC = 50000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP_CYC  = 1000,
  parameter int unsigned TIMEOUT_CYC    = 1000000,
  localparam int unsigned IDX_W   = $clog2(SCRIPT_DEPTH),
  localparam int unsigned RA_W    = 8 * REG_ADDR_BYTES,
  localparam int unsigned ENTRY_W = 2 + RA_W + 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [IDX_W-1:0]   o_rom_addr,
  input  logic [ENTRY_W-1:0] i_rom_data,
  output logic               o_mst_req,
  output logic               o_mst_rw,
  output logic [6:0]         o_mst_slave,
  output logic [RA_W-1:0]    o_mst_reg,
  output logic [7:0]         o_mst_wdata,
  input  logic               i_mst_done,
  input  logic               i_mst_nack,
  input  logic               i_mst_arb_lost,
  input  logic [7:0]         i_mst_rdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [2:0]         o_err_code,
  output logic [IDX_W-1:0]   o_err_index,
  output logic [7:0]         o_rd_val
);

  localparam int unsigned DLY_MAX  = 255 * DELAY_UNIT_CYC;
  localparam int unsigned CNT_MAX0 = (DLY_MAX > TIMEOUT_CYC) ? DLY_MAX : TIMEOUT_CYC;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > RETRY_GAP_CYC) ? CNT_MAX0 : RETRY_GAP_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_DELAY  = 2'd1;
  localparam logic [1:0] OP_VERIFY = 2'd2;
  localparam logic [1:0] OP_END    = 2'd3;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_ISSUE  = 4'd3;
  localparam logic [3:0] ST_WAIT   = 4'd4;
  localparam logic [3:0] ST_DELAY  = 4'd5;
  localparam logic [3:0] ST_GAP    = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_ERROR  = 4'd8;

  logic [3:0]         state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;
  logic [7:0]         rd_val_q, rd_val_d;
  logic               fail, advance;
  logic [2:0]         fail_code;

  logic [1:0] rom_op, entry_op;
  assign rom_op   = i_rom_data[ENTRY_W-1 -: 2];
  assign entry_op = entry_q[ENTRY_W-1 -: 2];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    entry_d     = entry_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    rd_val_d    = rd_val_q;
    fail        = 1'b0;
    fail_code   = 3'd0;
    advance     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d     = ST_FETCH;
          index_d     = '0;
          retry_d     = '0;
          err_code_d  = 3'd0;
          err_index_d = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        entry_d = i_rom_data;
        case (rom_op)
          OP_DELAY: begin
            cnt_d   = CNT_W'(DELAY_UNIT_CYC * 32'(i_rom_data[7:0]));
            state_d = ST_DELAY;
          end
          OP_END:  state_d = ST_DONE;
          default: state_d = ST_ISSUE;
        endcase
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mst_done) begin
          // Arbitration loss outranks NACK: the bus is no longer ours to retry on.
          if (i_mst_arb_lost) begin
            fail      = 1'b1;
            fail_code = 3'd2;
          end else if (i_mst_nack) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              cnt_d   = CNT_W'(RETRY_GAP_CYC);
              state_d = ST_GAP;
            end else begin
              fail      = 1'b1;
              fail_code = 3'd1;
            end
          end else if (entry_op == OP_VERIFY) begin
            rd_val_d = i_mst_rdata;
            if (i_mst_rdata != entry_q[7:0]) begin
              fail      = 1'b1;
              fail_code = 3'd3;
            end else begin
              advance = 1'b1;
            end
          end else begin
            advance = 1'b1;
          end
        end else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
          fail      = 1'b1;
          fail_code = 3'd4;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_GAP: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_ISSUE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      retry_d = '0;
      if (index_q == IDX_W'(SCRIPT_DEPTH - 1)) begin
        fail      = 1'b1;
        fail_code = 3'd5;
      end else begin
        index_d = index_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
    if (fail) begin
      state_d     = ST_ERROR;
      err_code_d  = fail_code;
      err_index_d = index_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      entry_q     <= '0;
      err_code_q  <= 3'd0;
      err_index_q <= '0;
      rd_val_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      rd_val_q    <= rd_val_d;
    end
  end

  assign o_rom_addr  = index_q;
  assign o_mst_req   = (state_q == ST_ISSUE);
  assign o_mst_rw    = (entry_op == OP_VERIFY);
  assign o_mst_slave = SLAVE_ADDR;
  assign o_mst_reg   = entry_q[8 +: RA_W];
  assign o_mst_wdata = entry_q[7:0];
  assign o_busy      = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign o_done      = (state_q == ST_DONE);
  assign o_error     = (state_q == ST_ERROR);
  assign o_err_code  = err_code_q;
  assign o_err_index = err_index_q;
  assign o_rd_val    = rd_val_q;

endmodule

// File: tb/tb_i2c_reg_script_seq.sv
// Bench for i2c_reg_script_seq: sync ROM model, responding I2C master model and a
// scoreboard of expected transactions popped as each o_mst_req is seen.
module tb_i2c_reg_script_seq;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DU      = 10;
  localparam int unsigned MR      = 3;
  localparam int unsigned GAP     = 20;
  localparam int unsigned TO      = 200;
  localparam int unsigned LAT     = 3;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned ENTRY_W = 26;

  localparam logic [1:0] OP_W = 2'd0, OP_D = 2'd1, OP_V = 2'd2, OP_E = 2'd3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [IDX_W-1:0]   rom_addr;
  logic [ENTRY_W-1:0] rom_data = '0;
  logic               mst_req, mst_rw;
  logic [6:0]         mst_slave;
  logic [15:0]        mst_reg;
  logic [7:0]         mst_wdata;
  logic               mst_done = 1'b0, mst_nack = 1'b0, mst_arb = 1'b0;
  logic [7:0]         mst_rdata = 8'd0;
  logic               busy, done, error;
  logic [2:0]         err_code;
  logic [IDX_W-1:0]   err_index;
  logic [7:0]         rd_val;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  i2c_reg_script_seq #(
    .SLAVE_ADDR    (7'h60),
    .REG_ADDR_BYTES(2),
    .SCRIPT_DEPTH  (DEPTH),
    .DELAY_UNIT_CYC(DU),
    .MAX_RETRY     (MR),
    .RETRY_GAP_CYC (GAP),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_mst_req     (mst_req),
    .o_mst_rw      (mst_rw),
    .o_mst_slave   (mst_slave),
    .o_mst_reg     (mst_reg),
    .o_mst_wdata   (mst_wdata),
    .i_mst_done    (mst_done),
    .i_mst_nack    (mst_nack),
    .i_mst_arb_lost(mst_arb),
    .i_mst_rdata   (mst_rdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_err_code    (err_code),
    .o_err_index   (err_index),
    .o_rd_val      (rd_val)
  );

  initial forever #5 clk = ~clk;

  logic [ENTRY_W-1:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Master model knobs and scoreboard
  int          nack_left = 0;
  bit          nack_all = 0, arb_next = 0, no_done = 0;
  logic [7:0]  rd_byte = 8'd0;
  int          pend = 0;
  logic [24:0] exp_q [$];
  int          req_cyc [$];

  always @(negedge clk) begin
    logic [24:0] exp_t;
    cyc++;
    mst_done = 1'b0; mst_nack = 1'b0; mst_arb = 1'b0; mst_rdata = 8'd0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mst_done  = 1'b1;
          mst_arb   = arb_next;
          mst_rdata = rd_byte;
          if (nack_all || nack_left > 0) begin
            mst_nack = 1'b1;
            if (nack_left > 0) nack_left--;
          end
        end
      end
      if (mst_req) begin
        req_cyc.push_back(cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_req: got rw=%0b reg=%h wdata=%h, expected no request",
                   mst_rw, mst_reg, mst_wdata);
        end else begin
          exp_t = exp_q.pop_front();
          if ({mst_rw, mst_reg, mst_wdata} !== exp_t) begin
            n_err++;
            $display("FAIL req_fields: got %h, expected %h", {mst_rw, mst_reg, mst_wdata}, exp_t);
          end
        end
        n_vec++;
        if (mst_slave !== 7'h60) begin
          n_err++;
          $display("FAIL req_slave: got %h, expected 60", mst_slave);
        end
        if (!no_done) pend = LAT;
      end
    end
  end

  function automatic logic [ENTRY_W-1:0] ent(logic [1:0] op, logic [15:0] ra, logic [7:0] v);
    return {op, ra, v};
  endfunction

  task automatic clear_knobs();
    nack_left = 0; nack_all = 0; arb_next = 0; no_done = 0; rd_byte = 8'd0;
    req_cyc.delete();
    exp_q.delete();
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ended);
    ended = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        ended = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, error, err_code, err_index, rd_val, mst_req, mst_rw} !== '0) begin
      n_err++;
      $display("FAIL reset_status: got b%0b d%0b e%0b c%0d i%0d rv%h rq%0b rw%0b, expected all 0",
               busy, done, error, err_code, err_index, rd_val, mst_req, mst_rw);
    end
    n_vec++;
    if ({rom_addr, mst_reg, mst_wdata} !== '0 || mst_slave !== 7'h60) begin
      n_err++;
      $display("FAIL reset_bus: got addr=%0d reg=%h wd=%h slave=%h, expected 0/0000/00/60",
               rom_addr, mst_reg, mst_wdata, mst_slave);
    end
    rst = 1'b0;
  endtask

  task automatic test_script();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0103, 8'h01);
    rom[1] = ent(OP_D, 16'h0000, 8'd5);
    rom[2] = ent(OP_V, 16'h300A, 8'h92);
    rom[3] = ent(OP_E, 16'h0000, 8'h00);
    rd_byte = 8'h92;
    exp_q.push_back({1'b0, 16'h0103, 8'h01});
    exp_q.push_back({1'b1, 16'h300A, 8'h92});
    kick();
    // A start pulse while busy must not restart the script.
    for (int i = 0; i < 50 && req_cyc.size() == 0; i++) @(negedge clk);
    kick();
    wait_end(2000, ended);
    n_vec++;
    if (!ended || done !== 1'b1 || error !== 1'b0 || err_code !== 3'd0) begin
      n_err++;
      $display("FAIL script_done: got ended=%0b done=%0b err=%0b code=%0d, expected 1/1/0/0",
               ended, done, error, err_code);
    end
    n_vec++;
    if (req_cyc.size() != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL script_reqs: got %0d reqs, %0d pending, expected 2/0",
               req_cyc.size(), exp_q.size());
    end else begin
      n_vec++;
      if (req_cyc[1] - req_cyc[0] < 5 * DU || req_cyc[1] - req_cyc[0] > 5 * DU + 20) begin
        n_err++;
        $display("FAIL script_delay: got gap %0d cycles, expected %0d..%0d",
                 req_cyc[1] - req_cyc[0], 5 * DU, 5 * DU + 20);
      end
    end
    n_vec++;
    if (rd_val !== 8'h92 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL script_rdval: got rd_val=%h busy=%0b, expected 92/0", rd_val, busy);
    end
  endtask

  task automatic test_retry();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0200, 8'hAA);
    rom[1] = ent(OP_E, 16'h0000, 8'h00);
    nack_left = 2;
    repeat (3) exp_q.push_back({1'b0, 16'h0200, 8'hAA});
    kick();
    wait_end(1000, ended);
    n_vec++;
    if (!ended || done !== 1'b1 || error !== 1'b0 || req_cyc.size() != 3) begin
      n_err++;
      $display("FAIL retry_done: got ended=%0b done=%0b err=%0b reqs=%0d, expected 1/1/0/3",
               ended, done, error, req_cyc.size());
    end
    for (int i = 1; i < req_cyc.size(); i++) begin
      n_vec++;
      if (req_cyc[i] - req_cyc[i-1] < GAP || req_cyc[i] - req_cyc[i-1] > GAP + 10) begin
        n_err++;
        $display("FAIL retry_gap%0d: got %0d cycles, expected %0d..%0d",
                 i, req_cyc[i] - req_cyc[i-1], GAP, GAP + 10);
      end
    end
  endtask

  task automatic test_nack_always();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0300, 8'h55);
    rom[1] = ent(OP_E, 16'h0000, 8'h00);
    nack_all = 1;
    repeat (MR + 1) exp_q.push_back({1'b0, 16'h0300, 8'h55});
    kick();
    wait_end(1000, ended);
    repeat (100) @(negedge clk);
    n_vec++;
    if (!ended || error !== 1'b1 || err_code !== 3'd1 || err_index !== 2'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL nack_err: got ended=%0b err=%0b code=%0d idx=%0d done=%0b, expected 1/1/1/0/0",
               ended, error, err_code, err_index, done);
    end
    n_vec++;
    if (req_cyc.size() != MR + 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL nack_count: got %0d reqs busy=%0b, expected %0d/0",
               req_cyc.size(), busy, MR + 1);
    end
  endtask

  task automatic test_verify_mismatch();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_V, 16'h300B, 8'h81);
    rom[1] = ent(OP_W, 16'h0001, 8'h01);
    rom[2] = ent(OP_E, 16'h0000, 8'h00);
    rd_byte = 8'h80;
    exp_q.push_back({1'b1, 16'h300B, 8'h81});
    kick();
    wait_end(1000, ended);
    repeat (50) @(negedge clk);
    n_vec++;
    if (!ended || error !== 1'b1 || err_code !== 3'd3 || rd_val !== 8'h80 || err_index !== 2'd0) begin
      n_err++;
      $display("FAIL verify_err: got ended=%0b err=%0b code=%0d rd_val=%h idx=%0d, expected 1/1/3/80/0",
               ended, error, err_code, rd_val, err_index);
    end
  endtask

  task automatic test_timeout();
    bit ended;
    int dt;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0104, 8'h02);
    rom[1] = ent(OP_E, 16'h0000, 8'h00);
    no_done = 1;
    exp_q.push_back({1'b0, 16'h0104, 8'h02});
    kick();
    wait_end(TO + 100, ended);
    dt = (req_cyc.size() > 0) ? cyc - req_cyc[0] : -1;
    n_vec++;
    if (!ended || error !== 1'b1 || err_code !== 3'd4) begin
      n_err++;
      $display("FAIL timeout_err: got ended=%0b err=%0b code=%0d, expected 1/1/4",
               ended, error, err_code);
    end
    n_vec++;
    if (dt < int'(TO) || dt > int'(TO) + 5) begin
      n_err++;
      $display("FAIL timeout_time: got %0d cycles, expected %0d..%0d", dt, TO, TO + 5);
    end
  endtask

  task automatic test_arb_lost();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0105, 8'h03);
    rom[1] = ent(OP_E, 16'h0000, 8'h00);
    arb_next = 1;
    nack_all = 1;
    exp_q.push_back({1'b0, 16'h0105, 8'h03});
    kick();
    wait_end(1000, ended);
    repeat (50) @(negedge clk);
    n_vec++;
    if (!ended || error !== 1'b1 || err_code !== 3'd2 || req_cyc.size() != 1) begin
      n_err++;
      $display("FAIL arb_err: got ended=%0b err=%0b code=%0d reqs=%0d, expected 1/1/2/1",
               ended, error, err_code, req_cyc.size());
    end
  endtask

  task automatic test_overrun();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0001, 8'h11);
    rom[1] = ent(OP_W, 16'h0002, 8'h22);
    rom[2] = ent(OP_D, 16'h0000, 8'h00);
    rom[3] = ent(OP_W, 16'h0003, 8'h33);
    exp_q.push_back({1'b0, 16'h0001, 8'h11});
    exp_q.push_back({1'b0, 16'h0002, 8'h22});
    exp_q.push_back({1'b0, 16'h0003, 8'h33});
    kick();
    wait_end(1000, ended);
    n_vec++;
    if (!ended || error !== 1'b1 || err_code !== 3'd5 || err_index !== 2'd3) begin
      n_err++;
      $display("FAIL overrun_err: got ended=%0b err=%0b code=%0d idx=%0d, expected 1/1/5/3",
               ended, error, err_code, err_index);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL overrun_reqs: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ended;
    clear_knobs();
    rom[0] = ent(OP_W, 16'h0106, 8'h07);
    rom[1] = ent(OP_E, 16'h0000, 8'h00);
    no_done = 1;
    exp_q.push_back({1'b0, 16'h0106, 8'h07});
    kick();
    for (int i = 0; i < 50 && req_cyc.size() == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, error, err_code, mst_req, rom_addr, mst_reg, mst_wdata} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got b%0b d%0b e%0b c%0d rq%0b a%0d reg=%h wd=%h, expected all 0",
               busy, done, error, err_code, mst_req, rom_addr, mst_reg, mst_wdata);
    end
    rst = 1'b0;
    no_done = 0;
    exp_q.push_back({1'b0, 16'h0106, 8'h07});
    kick();
    wait_end(1000, ended);
    n_vec++;
    if (!ended || done !== 1'b1 || error !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_restart: got ended=%0b done=%0b err=%0b pending=%0d, expected 1/1/0/0",
               ended, done, error, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = '0;
    test_reset();
    test_script();
    test_retry();
    test_nack_always();
    test_verify_mismatch();
    test_timeout();
    test_arb_lost();
    test_overrun();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
